// File: rtl/swiwf_div_pkg.sv
// rtl/swiwf_div_pkg.sv - shared FSM encoding, width helpers and saturation constant for fixed-point blocks
package swiwf_div_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIN  = 2'd2
   } state_e;

   function automatic int calc_w(input int wi, input int wf);
      return wi + wf;
   endfunction

   // Numerator is the dividend pre-scaled by 2^wf, so it carries wf extra bits.
   function automatic int calc_na(input int wi, input int wf);
      return wi + 2 * wf;
   endfunction

   function automatic logic [63:0] sat_max(input int w);
      return (64'd1 << (w - 1)) - 64'd1;
   endfunction

endpackage

// File: rtl/swiwf_div_step.sv
// rtl/swiwf_div_step.sv - one restoring-division step: shift in a numerator bit, conditionally subtract
module swiwf_div_step #(
   parameter int WB = 19
) (
   input  logic [WB:0]   rem_i,
   input  logic          nbit_i,
   input  logic [WB-1:0] divisor_i,
   output logic [WB:0]   rem_o,
   output logic          qbit_o
);

   logic [WB+1:0] shifted;
   logic [WB+1:0] diff;

   always_comb begin
      shifted = {rem_i, nbit_i};
      diff    = shifted - {2'b00, divisor_i};
      qbit_o  = (shifted >= {2'b00, divisor_i});
      rem_o   = qbit_o ? diff[WB:0] : shifted[WB:0];
   end

endmodule

// File: rtl/swiwf_div.sv
// rtl/swiwf_div.sv - iterative signed fixed-point divider, one quotient bit per clock, start/done handshake
module swiwf_div
   import swiwf_div_pkg::*;
#(
   parameter int width_int_a = 13,
   parameter int width_int_b = 3,
   parameter int width_frac  = 16,
   localparam int WA = calc_w(width_int_a, width_frac),
   localparam int WB = calc_w(width_int_b, width_frac),
   localparam int NA = calc_na(width_int_a, width_frac),
   localparam int CW = $clog2(NA)
) (
   input  logic          CLK,
   input  logic          NRST,
   input  logic          START,
   input  logic [WA-1:0] DIVA,
   input  logic [WB-1:0] DIVB,
   output logic          BUSY,
   output logic          DONE,
   output logic [WA-1:0] QUO,
   output logic          OVF,
   output logic          DZ
);

   localparam logic [WA-1:0] QMAX = WA'(sat_max(WA));

   state_e        state_q, state_d;
   logic          sa_q, sa_d;
   logic          sp_q, sp_d;
   logic [WB-1:0] bmag_q, bmag_d;
   logic [NA-1:0] n_q, n_d;
   logic [NA-1:0] q_q, q_d;
   logic [WB:0]   rem_q, rem_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [WA-1:0] quo_q, quo_d;
   logic          ovf_q, ovf_d;
   logic          dz_q, dz_d;
   logic          done_q, done_d;

   logic [WB:0]   rem_next;
   logic          qbit;
   logic [WA-1:0] amag;
   logic [WA-1:0] qmag;

   swiwf_div_step #(.WB(WB)) u_step (
      .rem_i     (rem_q),
      .nbit_i    (n_q[NA-1]),
      .divisor_i (bmag_q),
      .rem_o     (rem_next),
      .qbit_o    (qbit)
   );

   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sp_d    = sp_q;
      bmag_d  = bmag_q;
      n_d     = n_q;
      q_d     = q_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      ovf_d   = ovf_q;
      dz_d    = dz_q;
      done_d  = 1'b0;
      amag    = '0;
      qmag    = '0;
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               // Full-width magnitudes keep the most-negative input exact.
               amag    = DIVA[WA-1] ? -DIVA : DIVA;
               sa_d    = DIVA[WA-1];
               sp_d    = DIVA[WA-1] ^ DIVB[WB-1];
               bmag_d  = DIVB[WB-1] ? -DIVB : DIVB;
               n_d     = {amag, {width_frac{1'b0}}};
               q_d     = '0;
               rem_d   = '0;
               cnt_d   = CW'(NA - 1);
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            rem_d = rem_next;
            q_d   = {q_q[NA-2:0], qbit};
            n_d   = n_q << 1;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) state_d = ST_FIN;
         end
         ST_FIN: begin
            done_d  = 1'b1;
            dz_d    = (bmag_q == '0);
            state_d = ST_IDLE;
            if (bmag_q == '0) begin
               ovf_d = 1'b1;
               quo_d = sa_q ? -QMAX : QMAX;
            end else begin
               // Symmetric saturation: the magnitude never exceeds QMAX in either sign.
               ovf_d = |q_q[NA-1:WA-1];
               qmag  = ovf_d ? QMAX : {1'b0, q_q[WA-2:0]};
               quo_d = sp_q ? -qmag : qmag;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         state_q <= ST_IDLE;
         sa_q    <= 1'b0;
         sp_q    <= 1'b0;
         bmag_q  <= '0;
         n_q     <= '0;
         q_q     <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         quo_q   <= '0;
         ovf_q   <= 1'b0;
         dz_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sp_q    <= sp_d;
         bmag_q  <= bmag_d;
         n_q     <= n_d;
         q_q     <= q_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         ovf_q   <= ovf_d;
         dz_q    <= dz_d;
         done_q  <= done_d;
      end
   end

   assign BUSY = (state_q != ST_IDLE);
   assign DONE = done_q;
   assign QUO  = quo_q;
   assign OVF  = ovf_q;
   assign DZ   = dz_q;

endmodule

// File: tb/tb_swiwf_div.sv
// tb/tb_swiwf_div.sv - directed self-checking bench for swiwf_div
`define CHK(TAG, OBS, EXP) \
   begin \
      vectors++; \
      assert ((OBS) === (EXP)) else begin \
         miscompares++; \
         $error("FAIL %s observed=%0h expected=%0h", TAG, OBS, EXP); \
      end \
   end

module tb_swiwf_div;

   logic        CLK;
   logic        NRST;
   logic        START;
   logic [28:0] DIVA;
   logic [18:0] DIVB;
   logic        BUSY;
   logic        DONE;
   logic [28:0] QUO;
   logic        OVF;
   logic        DZ;

   int vectors     = 0;
   int miscompares = 0;

   swiwf_div dut (
      .CLK   (CLK),
      .NRST  (NRST),
      .START (START),
      .DIVA  (DIVA),
      .DIVB  (DIVB),
      .BUSY  (BUSY),
      .DONE  (DONE),
      .QUO   (QUO),
      .OVF   (OVF),
      .DZ    (DZ)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic launch(input logic [28:0] a, input logic [18:0] b);
      @(negedge CLK);
      DIVA  = a;
      DIVB  = b;
      START = 1'b1;
      @(posedge CLK);
      #1 START = 1'b0;
   endtask

   task automatic wait_done(input bit scramble, output int lat, output bit busy_ok);
      lat     = 0;
      busy_ok = 1'b1;
      @(negedge CLK);
      while (DONE !== 1'b1 && lat < 100) begin
         if (BUSY !== 1'b1) busy_ok = 1'b0;
         if (scramble) begin
            DIVA = 29'($urandom);
            DIVB = 19'($urandom);
         end
         @(negedge CLK);
         lat++;
      end
      vectors++;
      if (DONE !== 1'b1) begin
         miscompares++;
         $error("FAIL wait_done expired after %0d cycles without DONE", lat);
      end
   endtask

   task automatic check_reset_state(input string tag);
      vectors++;
      if (BUSY !== 1'b0 || DONE !== 1'b0 || QUO !== 29'h0 || OVF !== 1'b0 || DZ !== 1'b0) begin
         miscompares++;
         $error("FAIL %s reset state busy=%0b done=%0b quo=%0h ovf=%0b dz=%0b",
                tag, BUSY, DONE, QUO, OVF, DZ);
      end
   endtask

   task automatic check_result(input string tag, input logic [28:0] eq, input logic eovf,
                               input logic edz, input int lat, input bit busy_ok);
      `CHK({tag, "_latency"}, lat, 46)
      `CHK({tag, "_busy_during"}, busy_ok, 1'b1)
      `CHK({tag, "_busy_at_done"}, BUSY, 1'b0)
      `CHK({tag, "_quo"}, QUO, eq)
      `CHK({tag, "_ovf"}, OVF, eovf)
      `CHK({tag, "_dz"}, DZ, edz)
   endtask

   task automatic run_op(input string tag, input logic [28:0] a, input logic [18:0] b,
                         input logic [28:0] eq, input logic eovf, input logic edz);
      int lat;
      bit ok;
      launch(a, b);
      wait_done(1'b0, lat, ok);
      check_result(tag, eq, eovf, edz, lat, ok);
   endtask

   initial begin
      int lat;
      bit ok;
      int done_seen;

      NRST  = 1'b0;
      START = 1'b0;
      DIVA  = '0;
      DIVB  = '0;
      repeat (3) @(negedge CLK);
      check_reset_state("rst_state");
      `CHK("rst_busy", BUSY, 1'b0)
      `CHK("rst_done", DONE, 1'b0)
      `CHK("rst_quo", QUO, 29'h0)
      `CHK("rst_ovf", OVF, 1'b0)
      `CHK("rst_dz", DZ, 1'b0)
      NRST = 1'b1;

      run_op("t1_3by1p5", 29'h0030000, 19'h18000, 29'h0020000, 1'b0, 1'b0);
      @(negedge CLK);
      `CHK("t1_done_pulse", DONE, 1'b0)
      `CHK("t1_quo_hold", QUO, 29'h0020000)

      run_op("t2_m7p5by2", 29'h1FF88000, 19'h20000, 29'h1FFC4000, 1'b0, 1'b0);
      run_op("t2_1by3", 29'h0010000, 19'h30000, 29'h0005555, 1'b0, 1'b0);
      run_op("t2_m1by3", 29'h1FFF0000, 19'h30000, 29'h1FFFAAAB, 1'b0, 1'b0);

      run_op("t3_ovf_pos", 29'h0FFF0000, 19'h00001, 29'h0FFFFFFF, 1'b1, 1'b0);
      run_op("t3_ovf_minneg", 29'h10000000, 19'h70000, 29'h0FFFFFFF, 1'b1, 1'b0);

      run_op("t4_dz_neg", 29'h1FFF0000, 19'h00000, 29'h10000001, 1'b1, 1'b1);
      run_op("t4_dz_zero", 29'h0000000, 19'h00000, 29'h0FFFFFFF, 1'b1, 1'b1);
      run_op("t4_zero_quo", 29'h0000000, 19'h30000, 29'h0000000, 1'b0, 1'b0);

      @(negedge CLK);
      DIVA  = 29'h0030000;
      DIVB  = 19'h18000;
      START = 1'b1;
      @(posedge CLK);
      wait_done(1'b1, lat, ok);
      check_result("t5_hold", 29'h0020000, 1'b0, 1'b0, lat, ok);
      DIVA = 29'h0010000;
      DIVB = 19'h30000;
      @(posedge CLK);
      #1 START = 1'b0;
      wait_done(1'b0, lat, ok);
      check_result("t5_b2b", 29'h0005555, 1'b0, 1'b0, lat, ok);

      launch(29'h0030000, 19'h18000);
      repeat (20) @(negedge CLK);
      NRST = 1'b0;
      #1;
      check_reset_state("t6_rst_state");
      `CHK("t6_rst_busy", BUSY, 1'b0)
      `CHK("t6_rst_done", DONE, 1'b0)
      `CHK("t6_rst_quo", QUO, 29'h0)
      `CHK("t6_rst_ovf", OVF, 1'b0)
      `CHK("t6_rst_dz", DZ, 1'b0)
      @(negedge CLK);
      NRST      = 1'b1;
      done_seen = 0;
      repeat (60) begin
         @(negedge CLK);
         if (DONE === 1'b1) done_seen++;
      end
      `CHK("t6_no_done", done_seen, 0)
      run_op("t6_after", 29'h1FF88000, 19'h20000, 29'h1FFC4000, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
